mem_access_stage: RTL and testbench

MEM pipeline stage of the 5-stage RISC-V core. It sits directly downstream of the EX/MEM pipeline register and consumes that register's control bits, ALU result, store data and destination register. It performs loads and stores against a variable-latency data memory through a req/ack handshake and stalls the upstream pipeline until each access completes. It also contains the MEM/WB pipeline register that feeds write-back and forwarding.

---
 rtl/mem_access_stage.sv | 156 +++++++++++++++
 tb/tb_mem_access_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage RISC-V core.
// Issues loads/stores to a variable-latency data memory over a req/ack
// handshake, stalls upstream until each access completes, and holds the
// MEM/WB pipeline register that feeds write-back and forwarding.
module mem_access_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // EX/MEM inputs
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [4:0]        RDaddr_i,
    // data memory handshake
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // pipeline control
    output logic              stall_o,
    output logic              misalign_o,
    // MEM/WB outputs
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] MemData_o,
    output logic [4:0]        RDaddr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_misalign;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_memdata;
    logic [4:0]        r_rd;

    logic w_mem_op;
    logic w_aligned;
    logic w_access;
    logic w_misalign;
    logic w_stall;

    assign w_mem_op   = MemRead_i | MemWrite_i;
    assign w_aligned  = (ALUResult_i[1:0] == 2'b00);
    assign w_access   = w_mem_op & w_aligned;
    assign w_misalign = w_mem_op & ~w_aligned;

    // NOTE: stall is partly combinational on the inputs, so it is gated by
    // rst_i to read 0 while reset is held even with an access presented.
    assign w_stall = rst_i & (((r_state == ST_IDLE) & w_access) | (r_state == ST_BUSY));

    // Access FSM: latch the request on IDLE->BUSY, wait for ack, one DONE cycle.
    // NOTE: every sequential block uses non-blocking assignments so all
    // registers update from pre-edge values regardless of block order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_state     <= ST_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= MemWrite_i;
                        r_mem_addr  <= ALUResult_i;
                        r_mem_wdata <= RS2data_i;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack_i) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                        r_rdata   <= r_mem_we ? '0 : mem_rdata_i;
                    end
                end
                ST_DONE: begin
                    // The finished instruction is still on the inputs; do not re-issue it.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Sticky misalignment flag: set when a misaligned access is dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_misalign <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_misalign) begin
            r_misalign <= 1'b1;
        end
    end

    // MEM/WB register: bubble while stalling, otherwise take the instruction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alu      <= '0;
            r_memdata  <= '0;
            r_rd       <= '0;
        end else if (w_stall) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alu      <= ALUResult_i;
            r_memdata  <= '0;
            r_rd       <= RDaddr_i;
        end else begin
            // A dropped misaligned access must not write the register file.
            r_regwrite <= RegWrite_i & ~w_misalign;
            r_memtoreg <= MemtoReg_i;
            r_alu      <= ALUResult_i;
            r_memdata  <= (r_state == ST_DONE) ? r_rdata : '0;
            r_rd       <= RDaddr_i;
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign stall_o     = w_stall;
    assign misalign_o  = r_misalign;
    assign RegWrite_o  = r_regwrite;
    assign MemtoReg_o  = r_memtoreg;
    assign ALUResult_o = r_alu;
    assign MemData_o   = r_memdata;
    assign RDaddr_o    = r_rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage with a
// behavioural data memory responder and an instruction-level reference model.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUResult_i, RS2data_i;
    logic [4:0]  RDaddr_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o, misalign_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ALUResult_o, MemData_o;
    logic [4:0]  RDaddr_o;

    mem_access_stage #(.DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .ALUResult_i(ALUResult_i), .RS2data_i(RS2data_i), .RDaddr_i(RDaddr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .misalign_o(misalign_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .ALUResult_o(ALUResult_o), .MemData_o(MemData_o), .RDaddr_o(RDaddr_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic        mis;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [4:0]  rd;
        int          stalls;
        int          reqs;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] ram[logic [31:0]];
    logic        ref_mis = 1'b0;
    bit          mon_en = 1'b0;
    bit          ack_always = 1'b0;
    bit          aborted = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(mem_req_o), 0);
        check({tag, "_we"},    32'(mem_we_o), 0);
        check({tag, "_addr"},  mem_addr_o, 0);
        check({tag, "_wdata"}, mem_wdata_o, 0);
        check({tag, "_stall"}, 32'(stall_o), 0);
        check({tag, "_mis"},   32'(misalign_o), 0);
        check({tag, "_rw"},    32'(RegWrite_o), 0);
        check({tag, "_m2r"},   32'(MemtoReg_o), 0);
        check({tag, "_alu"},   ALUResult_o, 0);
        check({tag, "_mdata"}, MemData_o, 0);
        check({tag, "_rd"},    32'(RDaddr_o), 0);
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
        RegWrite_i  = rw;
        MemtoReg_i  = m2r;
        MemRead_i   = mr;
        MemWrite_i  = mw;
        ALUResult_i = alu;
        RS2data_i   = rs2;
        RDaddr_i    = rd;
    endtask

    // Reference model: what one instruction should leave in MEM/WB, how long
    // it stalls, and which memory request it should produce.
    task automatic issue(input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                         input int lat);
        exp_t e;
        req_t r;
        drive(rw, m2r, mr, mw, alu, rs2, rd);
        e.rw = rw; e.m2r = m2r; e.alu = alu; e.rd = rd;
        e.mdata = 32'd0; e.stalls = 0; e.reqs = 0;
        if ((mr || mw) && alu[1:0] == 2'b00) begin
            e.stalls = lat + 2;
            e.reqs   = lat + 1;
            r.we = mw; r.addr = alu; r.wdata = rs2; r.lat = lat;
            req_q.push_back(r);
            if (mw) ref_mem[alu] = rs2;
            else    e.mdata = ref_mem.exists(alu) ? ref_mem[alu] : mem_default(alu);
        end else if (mr || mw) begin
            e.rw    = 1'b0;
            ref_mis = 1'b1;
        end
        e.mis = ref_mis;
        exp_q.push_back(e);
    endtask

    // Hold the instruction until the edge that retires it (stall_o low).
    task automatic wait_retire();
        int n = 0;
        forever begin
            @(negedge clk_i);
            if (stall_o === 1'b0) break;
            n++;
            if (n > 60) begin
                check("retire_timeout", 1, 0);
                aborted = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input logic rw, input logic m2r, input logic mr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input int lat);
        if (!aborted) begin
            issue(rw, m2r, mr, mw, alu, rs2, rd, lat);
            wait_retire();
        end
    endtask

    // Retire a nop and let the monitor consume it before pausing.
    task automatic pause_monitor();
        run(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 0);
        @(negedge clk_i);
        #1;
        mon_en = 1'b0;
    endtask

    // Memory responder: acks each request after its chosen latency and
    // checks the request fields; throws spurious acks when idle.
    int   rsp_cnt = 0;
    req_t rsp_cur;
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        forever begin
            @(negedge clk_i);
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
            if (mem_req_o === 1'b1) begin
                if (rsp_cnt == 0) begin
                    if (req_q.size() == 0) begin
                        check("req_unexpected", 1, 0);
                        rsp_cur.we = mem_we_o; rsp_cur.addr = mem_addr_o;
                        rsp_cur.wdata = mem_wdata_o; rsp_cur.lat = 0;
                    end else begin
                        rsp_cur = req_q.pop_front();
                    end
                end
                check("req_addr", mem_addr_o, rsp_cur.addr);
                check("req_we", 32'(mem_we_o), 32'(rsp_cur.we));
                if (rsp_cur.we) check("req_wdata", mem_wdata_o, rsp_cur.wdata);
                if (rsp_cnt == rsp_cur.lat) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) ram[mem_addr_o] = mem_wdata_o;
                    else mem_rdata_i = ram.exists(mem_addr_o) ? ram[mem_addr_o] : mem_default(mem_addr_o);
                end
                rsp_cnt++;
            end else begin
                rsp_cnt = 0;
                if (ack_always || $urandom_range(0, 3) == 0) mem_ack_i = 1'b1;
            end
        end
    end

    // Monitor: each retirement edge pops one expectation; each stall edge must load a bubble.
    bit   mon_prev_valid = 1'b0;
    logic mon_prev_stall = 1'b0;
    int   mon_stalls = 0;
    int   mon_reqs = 0;
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk_i);
            if (!mon_en) begin
                mon_prev_valid = 1'b0;
                mon_stalls = 0;
                mon_reqs = 0;
                continue;
            end
            if (mon_prev_valid) begin
                if (mon_prev_stall) begin
                    check("bubble", {30'd0, RegWrite_o, MemtoReg_o}, 0);
                end else if (exp_q.size() == 0) begin
                    check("retire_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_regwrite", 32'(RegWrite_o), 32'(mon_e.rw));
                    check("wb_memtoreg", 32'(MemtoReg_o), 32'(mon_e.m2r));
                    check("wb_alu", ALUResult_o, mon_e.alu);
                    check("wb_memdata", MemData_o, mon_e.mdata);
                    check("wb_rd", 32'(RDaddr_o), 32'(mon_e.rd));
                    check("misalign", 32'(misalign_o), 32'(mon_e.mis));
                    check("stall_cycles", 32'(mon_stalls), 32'(mon_e.stalls));
                    check("req_cycles", 32'(mon_reqs), 32'(mon_e.reqs));
                    mon_stalls = 0;
                    mon_reqs = 0;
                end
            end
            if (mem_req_o === 1'b1) begin
                mon_reqs++;
                check("req_implies_stall", 32'(stall_o), 1);
            end
            if (stall_o === 1'b1) mon_stalls++;
            mon_prev_stall = stall_o;
            mon_prev_valid = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        logic        rw, m2r, mr, mw;
        logic [31:0] alu;
        int          k;

        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        repeat (4) begin
            @(posedge clk_i);
            #1;
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom));
            #2;
            check_reset_outputs("reset_hold");
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("post_reset_stall", 32'(stall_o), 0);
        end

        @(posedge clk_i);
        #1;
        mon_en = 1'b1;
        // ALU pass-through
        run(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 0);
        // Load with ack latency 3
        ram[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        run(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd9, 3);
        // Store with ack latency 0, then read it back
        run(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 5'd3, 0);
        run(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd4, 1);
        // Misaligned load, followed by many more instructions
        run(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd6, 0);

        for (int i = 0; i < 150 && !aborted; i++) begin
            k   = $urandom_range(0, 19);
            rw  = 1'($urandom);
            m2r = 1'($urandom);
            alu = 32'h400 + (32'($urandom_range(0, 31)) << 2);
            mr  = 1'b0;
            mw  = 1'b0;
            if (k < 8) begin
                alu = $urandom;
            end else if (k < 13) begin
                mr = 1'b1;
            end else if (k < 17) begin
                mw = 1'b1;
            end else if (k < 18) begin
                mr = 1'b1;
                mw = 1'b1;
            end else begin
                mr  = 1'($urandom);
                mw  = ~mr;
                alu = alu | 32'($urandom_range(1, 3));
            end
            run(rw, m2r, mr, mw, alu, $urandom, 5'($urandom), $urandom_range(0, 4));
        end

        // Reset in the middle of an access
        if (!aborted) begin
            pause_monitor();
            @(posedge clk_i);
            #1;
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd7);
            req_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, lat: 6});
            @(posedge clk_i);
            @(posedge clk_i);
            #3;
            check("busy_before_reset", 32'(mem_req_o), 1);
            rst_i = 1'b0;
            #1;
            check_reset_outputs("mid_reset");
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
            ref_mis = 1'b0;
            ack_always = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b1;
            repeat (3) begin
                @(negedge clk_i);
                #1;
                check("late_ack_req", 32'(mem_req_o), 0);
                check("late_ack_stall", 32'(stall_o), 0);
                check("late_ack_mdata", MemData_o, 0);
            end
            ack_always = 1'b0;
            @(posedge clk_i);
            #1;
            mon_en = 1'b1;
            run(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd7, 2);
            for (int i = 0; i < 12 && !aborted; i++) begin
                mr = 1'($urandom);
                mw = 1'($urandom);
                run(1'($urandom), 1'($urandom), mr, mw,
                    32'h400 + (32'($urandom_range(0, 31)) << 2), $urandom,
                    5'($urandom), $urandom_range(0, 3));
            end
        end

        if (!aborted) pause_monitor();
        check("exp_queue_drained", 32'(exp_q.size()), 0);
        check("req_queue_drained", 32'(req_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
